// File: rtl/mem_arbiter.sv
// Single-port memory arbiter between instruction fetch and data memory.
// One outstanding access; data side wins unless fetch has been starved STARVE_MAX times.
module mem_arbiter #(
    parameter int MEM_LAT    = 1,
    parameter int STARVE_MAX = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    input  logic        if_flush,
    output logic        if_gnt,
    output logic        if_rvalid,
    output logic [31:0] if_rdata,
    output logic        if_misaligned,
    input  logic        dm_req,
    input  logic        dm_we,
    input  logic [1:0]  dm_size,
    input  logic [31:0] dm_addr,
    input  logic [31:0] dm_wdata,
    output logic        dm_gnt,
    output logic        dm_rvalid,
    output logic [31:0] dm_rdata,
    output logic        dm_misaligned,
    output logic        mem_en,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    input  logic [31:0] mem_rdata
);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] BUSY = 1'b1;

    logic [0:0] state_q, state_d;
    logic [2:0] cnt_q, cnt_d;
    logic [2:0] stv_q, stv_d;
    logic       owner_dm_q, owner_dm_d;
    logic       store_q, store_d;
    logic       flushed_q, flushed_d;

    logic        resp, opp, pick_if;
    logic        if_g, dm_g, if_mis, dm_mis, if_acc, dm_acc;
    logic        if_rv, dm_rv;
    logic [3:0]  strb;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        resp    = (state_q == BUSY) && (cnt_q == 3'(MEM_LAT));
        opp     = (state_q == IDLE) || resp;
        pick_if = if_req && (!dm_req || (stv_q >= 3'(STARVE_MAX)));
        if_g    = opp && pick_if;
        dm_g    = opp && dm_req && !pick_if;

        if_mis = (if_addr[1:0] != 2'b00);
        case (dm_size)
            2'd0:    dm_mis = 1'b0;
            2'd1:    dm_mis = dm_addr[0];
            default: dm_mis = (dm_addr[1:0] != 2'b00);
        endcase
        if_acc = if_g && !if_mis;
        dm_acc = dm_g && !dm_mis;

        case (dm_size)
            2'd0:    strb = 4'b0001 << dm_addr[1:0];
            2'd1:    strb = 4'b0011 << dm_addr[1:0];
            default: strb = 4'b1111;
        endcase

        // A flush in the response cycle itself still counts against the fetch.
        if_rv = resp && !owner_dm_q && !flushed_q && !if_flush;
        dm_rv = resp && owner_dm_q;
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        owner_dm_d = owner_dm_q;
        store_d    = store_q;
        flushed_d  = flushed_q;

        if (!if_req || if_g)
            stv_d = 3'd0;
        else if (dm_g)
            stv_d = (stv_q == 3'd7) ? stv_q : stv_q + 3'd1;
        else
            stv_d = stv_q;

        if (if_acc || dm_acc) begin
            state_d    = BUSY;
            cnt_d      = 3'd1;
            owner_dm_d = dm_acc;
            store_d    = dm_acc && dm_we;
            flushed_d  = if_acc && if_flush;
        end else if (resp) begin
            state_d    = IDLE;
            cnt_d      = 3'd0;
            owner_dm_d = 1'b0;
            store_d    = 1'b0;
            flushed_d  = 1'b0;
        end else if (state_q == BUSY) begin
            cnt_d     = cnt_q + 3'd1;
            flushed_d = flushed_q || (!owner_dm_q && if_flush);
        end
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            cnt_q      <= 3'd0;
            stv_q      <= 3'd0;
            owner_dm_q <= 1'b0;
            store_q    <= 1'b0;
            flushed_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            stv_q      <= stv_d;
            owner_dm_q <= owner_dm_d;
            store_q    <= store_d;
            flushed_q  <= flushed_d;
        end
    end

    // Grants depend on live requests, so outputs are masked while reset is held.
    always_comb begin
        if_gnt        = rst && if_g;
        dm_gnt        = rst && dm_g;
        if_misaligned = rst && if_g && if_mis;
        dm_misaligned = rst && dm_g && dm_mis;
        if_rvalid     = rst && if_rv;
        dm_rvalid     = rst && dm_rv;
        if_rdata      = (rst && if_rv) ? mem_rdata : 32'd0;
        dm_rdata      = (rst && dm_rv && !store_q) ? mem_rdata : 32'd0;

        mem_en    = rst && (if_acc || dm_acc);
        mem_we    = rst && dm_acc && dm_we;
        mem_wdata = (rst && dm_acc) ? dm_wdata : 32'd0;
        mem_wstrb = (rst && dm_acc && dm_we) ? strb : 4'd0;
        if (rst && if_acc)
            mem_addr = {if_addr[31:2], 2'b00};
        else if (rst && dm_acc)
            mem_addr = {dm_addr[31:2], 2'b00};
        else
            mem_addr = 32'd0;
    end

endmodule
